// File: rtl/circuit_vec_driver.sv
// circuit_vec_driver: walks a 4-input gate circuit through all 16 vectors and checks its output
module circuit_vec_driver #(
    parameter int HOLD_CYCLES  = 8,
    parameter int SAMPLE_CYCLE = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       mismatch,
    output logic [4:0] err_cnt,
    output logic [3:0] first_err_vec,
    output logic       first_err_valid
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
    state_t     state_q, state_d;
    logic [3:0] vec_q, vec_d, fev_q, fev_d;
    logic [7:0] hold_q, hold_d;
    logic [4:0] err_q, err_d;
    logic       fv_q, fv_d, mis_q, mis_d, s1_q, s2_q;
    logic       exp_v, sample, last;
    assign exp_v  = (vec_q[2] & vec_q[1]) | (~vec_q[3] & ~vec_q[1] & vec_q[0]);
    assign sample = hold_q == 8'(SAMPLE_CYCLE);
    assign last   = hold_q == 8'(HOLD_CYCLES - 1);
    // next-state: vector stepping, compare at the sample point, result capture
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fv_d    = fv_q;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = APPLY;
                vec_d   = '0;
                hold_d  = '0;
                err_d   = '0;
                fev_d   = '0;
                fv_d    = 1'b0;
            end
            APPLY: begin
                hold_d = hold_q + 8'd1;
                if (sample && s2_q != exp_v) begin
                    mis_d = 1'b1;
                    err_d = err_q + 5'd1;
                    if (!fv_q) begin
                        fev_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end
                if (last) begin
                    hold_d = '0;
                    if (vec_q == 4'd15) begin
                        state_d = DONE;
                        vec_d   = '0;
                    end else vec_d = vec_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset aborts any run with all results cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            hold_q  <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fv_q    <= fv_d;
            mis_q   <= mis_d;
        end
    end
    // two-flop synchronizer for the asynchronous circuit output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= dut_out;
            s2_q <= s1_q;
        end
    end
    assign {a, b, c, d}    = vec_q;
    assign vec_idx         = vec_q;
    assign busy            = state_q == APPLY;
    assign done            = state_q == DONE;
    assign mismatch        = mis_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fv_q;
endmodule

// File: tb/tb_circuit_vec_driver.sv
// tb_circuit_vec_driver: directed checks of the vector driver against a modelled gate circuit
module tb_circuit_vec_driver;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, start4 = 1'b0;
    logic       dut_out, dut_out4;
    logic       a, b, c, d, busy, done, mismatch, first_err_valid;
    logic [3:0] vec_idx, first_err_vec;
    logic [4:0] err_cnt;
    logic       a4, b4, c4, d4, busy4, done4, mismatch4, fv4;
    logic [3:0] vec4, fev4;
    logic [4:0] err4;
    int         mode = 0;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    assign dut_out  = mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : ((b & c) | (~a & ~c & d));
    assign dut_out4 = (b4 & c4) | (~a4 & ~c4 & d4);

    circuit_vec_driver #(.HOLD_CYCLES(8), .SAMPLE_CYCLE(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .dut_out(dut_out),
        .a(a), .b(b), .c(c), .d(d), .vec_idx(vec_idx), .busy(busy), .done(done),
        .mismatch(mismatch), .err_cnt(err_cnt), .first_err_vec(first_err_vec),
        .first_err_valid(first_err_valid)
    );

    circuit_vec_driver #(.HOLD_CYCLES(4), .SAMPLE_CYCLE(3)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dut_out(dut_out4),
        .a(a4), .b(b4), .c(c4), .d(d4), .vec_idx(vec4), .busy(busy4), .done(done4),
        .mismatch(mismatch4), .err_cnt(err4), .first_err_vec(fev4),
        .first_err_valid(fv4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {11'd0, a, b, c, d, vec_idx, busy, done, mismatch, err_cnt, first_err_vec, first_err_valid};
    endfunction

    task automatic run(input int mode_i, input int restart_at, input logic [15:0] exp_mask,
                       input int exp_err, input int exp_fev, input int exp_fv, input string tag);
        int e = 0, done_at = -1, busy_n = 0, walk_bad = 0;
        logic [15:0] mask = '0;
        mode = mode_i;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (e < 300 && done_at < 0) begin
            start = (e == restart_at);
            if (done) done_at = e;
            if (busy) busy_n++;
            if (mismatch) mask[vec_idx] = 1'b1;
            if (busy && ({a, b, c, d} != vec_idx || vec_idx != 4'(e / 8))) walk_bad++;
            e++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_at"}, done_at, 128);
        chk({tag, "_busy_cycles"}, busy_n, 128);
        chk({tag, "_walk"}, walk_bad, 0);
        chk({tag, "_mis_mask"}, mask, exp_mask);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
        chk({tag, "_first_vec"}, first_err_vec, exp_fev);
        chk({tag, "_first_valid"}, first_err_valid, exp_fv);
        chk({tag, "_idle_after"}, {busy, done, a, b, c, d}, 0);
    endtask

    initial begin
        int n;
        int dn;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_out(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", all_out(), 0);

        run(0, -1, 16'h0000, 0, 0, 0, "good");
        run(1, -1, 16'hC0E2, 6, 1, 1, "tie0");
        run(2, -1, 16'h3F1D, 10, 0, 1, "tie1");
        run(0, 40, 16'h0000, 0, 0, 0, "restart_ignored");

        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vec_idx != 4'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec5", vec_idx, 5);
        #2 rst = 1'b1;
        #1 chk("async_abort", all_out(), 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("no_done_after_abort", dn, 0);
        run(0, -1, 16'h0000, 0, 0, 0, "post_abort");

        mode = 1;
        start = 1'b1;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("held_first_done", done, 1);
        chk("held_first_err", err_cnt, 6);
        @(negedge clk);
        chk("held_idle_gap", {busy, done}, 2'b00);
        @(negedge clk);
        chk("held_second_busy", busy, 1);
        chk("held_cleared", {err_cnt, first_err_valid}, 0);
        start = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("held_second_err", err_cnt, 6);
        @(negedge clk);
        mode = 0;

        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("h4_done_at", n, 64);
        chk("h4_err", {err4, fv4}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/circuit_vec_driver.md
Name: circuit_vec_driver

Overview:
- Upstream stimulus stage for the combinational gate circuit out = (b & c) | (~a & ~c & d).
- Steps the circuit's a, b, c, d inputs through all 16 combinations, holding each one for a programmable number of clocks.
- Samples the circuit's out through a synchronizer and checks it against the expected function.
- Reports the mismatch count and the first failing vector, replacing hand-written per-vector stimulus.

Parameters:
- HOLD_CYCLES, 8: clocks each vector is driven. Legal range 4..255.
- SAMPLE_CYCLE, 6: hold-count value at which the synchronized out is compared. Must satisfy 3 <= SAMPLE_CYCLE <= HOLD_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; sampled in IDLE only.
- dut_out  input  1  circuit output; asynchronous to clk.
- a  output  1  circuit input a = vec_idx[3].
- b  output  1  circuit input b = vec_idx[2].
- c  output  1  circuit input c = vec_idx[1].
- d  output  1  circuit input d = vec_idx[0].
- vec_idx  output  4  index of the vector currently driven.
- busy  output  1  high while vectors are being applied.
- done  output  1  one-cycle pulse at end of run.
- mismatch  output  1  one-cycle pulse per failing compare.
- err_cnt  output  5  failing vectors this run, 0..16.
- first_err_vec  output  4  index of the first failing vector.
- first_err_valid  output  1  first_err_vec holds a captured value.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset value of every output is 0. rst asserted mid-run aborts immediately: a..d return to 0000 and all state clears. No done pulse is issued.
- Synchronizer: dut_out passes through a 2-flop synchronizer (reset 0). All compares use the second flop, sync_out.
- Expected value: exp = (vec_idx[2] & vec_idx[1]) | (~vec_idx[3] & ~vec_idx[1] & vec_idx[0]). exp = 1 for indices 1, 5, 6, 7, 14, 15 only.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - a..d = 0000, busy = 0.
  - start = 1 at an edge -> APPLY on that edge.
  - On that same edge: vec_idx=0, hold_cnt=0, err_cnt=0, first_err_valid=0, first_err_vec=0, busy=1.
- APPLY:
  - hold_cnt (8 bits) increments every clock.
  - On the edge where hold_cnt == SAMPLE_CYCLE: if sync_out != exp, then mismatch=1 for the following cycle and err_cnt += 1.
  - If first_err_valid is 0 at that edge, also capture first_err_vec = vec_idx and set first_err_valid = 1.
  - On the edge where hold_cnt == HOLD_CYCLES-1:
    - vec_idx < 15: vec_idx += 1 and hold_cnt = 0.
    - vec_idx == 15: go to DONE. busy=0, done=1, a..d=0000, vec_idx=0.
- DONE: lasts one cycle, then IDLE on the next edge and done returns to 0.
- Result retention: err_cnt, first_err_vec and first_err_valid hold their values in IDLE until the next accepted start.
- Timing, with start accepted at edge 0:
  - Vector k is driven from edge k*HOLD_CYCLES through edge (k+1)*HOLD_CYCLES.
  - done is high between edges 16*HOLD_CYCLES and 16*HOLD_CYCLES+1.
- start while busy or in DONE is ignored. No restart and no queuing.
- start held high continuously causes back-to-back runs. Each new run is accepted from IDLE one cycle after DONE.
- err_cnt cannot exceed 16, so no wrap handling is needed.
- mismatch and the err_cnt update occur on the same edge.
- Timing constraint: clock period must be at least 10 time units. This guarantees the circuit's worst-case 5-unit path plus the synchronizer settles before the SAMPLE_CYCLE compare.

Test Plan:
- Correct circuit attached, HOLD_CYCLES=8, start pulsed -> a..d walk 0000..1111, busy high for 128 cycles, done pulse at cycle 128, err_cnt=0, first_err_valid=0, mismatch never high.
- dut_out tied 0 -> err_cnt=6, mismatch pulses during vectors 1, 5, 6, 7, 14, 15, first_err_vec=1, first_err_valid=1.
- dut_out tied 1 -> err_cnt=10, first_err_vec=0.
- start re-pulsed at cycle 40 of a run -> ignored, done still at cycle 128. Then rst asserted during vector 5 of a second run -> all outputs 0 immediately, no done pulse. A following start produces a full clean run, err_cnt=0.
- start held high -> two consecutive runs with one IDLE cycle between done and the next busy. Results cleared at the second start.
- HOLD_CYCLES=4, SAMPLE_CYCLE=3 with the correct circuit -> done at cycle 64, err_cnt=0.
